key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 The block SHALL have parameter DEBOUNCE_MS, default 20, debounce window in ms.
REQ-003 The block SHALL have parameter LONG_MS, default 1000, long-press threshold in ms, measured from press acceptance.
REQ-004 The block SHALL have parameter KEY_ACTIVE_LOW, default 1: 1 = key_in low means pressed; 0 = key_in high means pressed.
REQ-005 The block SHALL derive DB_CNT_MAX = CLK_FREQ/1000*DEBOUNCE_MS - 1 and LONG_CNT_MAX = CLK_FREQ/1000*LONG_MS - 1, both held in 32-bit counters, and SHALL require DB_CNT_MAX >= 1 and LONG_CNT_MAX > DB_CNT_MAX.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-008 The block SHALL have port key_in, input, 1 bit, the raw mechanical button, asynchronous to clk.
REQ-009 The block SHALL have port key_state, output, 1 bit, the debounced level: 1 = pressed.
REQ-010 The block SHALL have port key_press, output, 1 bit, a one-cycle pulse on each accepted press.
REQ-011 The block SHALL have port key_release, output, 1 bit, a one-cycle pulse on each accepted release.
REQ-012 The block SHALL have port key_long, output, 1 bit, a one-cycle pulse once per press when the hold reaches LONG_CNT_MAX.

Function
REQ-013 key_in SHALL pass through a 2-flop synchronizer and then be normalized by KEY_ACTIVE_LOW to an internal pressed bit p; the FSM SHALL sample only p.
REQ-014 The FSM SHALL have states IDLE, PRESS_DB, HELD and RELEASE_DB, plus a debounce counter db_cnt and a long counter long_cnt.
REQ-015 IDLE: p=1 SHALL move to PRESS_DB with db_cnt=0; p=0 SHALL stay in IDLE.
REQ-016 PRESS_DB: p=0 SHALL return to IDLE with no output pulse; p=1 with db_cnt<DB_CNT_MAX SHALL increment db_cnt; p=1 with db_cnt==DB_CNT_MAX SHALL move to HELD, set key_state=1, pulse key_press, and clear db_cnt and long_cnt.
REQ-017 Given key_in pressed and stable before rising edge 1, key_press SHALL be high for exactly the one cycle following edge DB_CNT_MAX+4.
REQ-018 HELD: p=0 SHALL move to RELEASE_DB with db_cnt=0; p=1 SHALL remain in HELD.
REQ-019 RELEASE_DB: p=1 SHALL return to HELD with no pulse, keeping key_state=1 and long_cnt; p=0 with db_cnt==DB_CNT_MAX SHALL move to IDLE, set key_state=0 and pulse key_release; otherwise db_cnt SHALL increment.
REQ-020 long_cnt SHALL increment every cycle in HELD or RELEASE_DB.
REQ-021 When long_cnt==LONG_CNT_MAX, key_long SHALL pulse once, after which long_cnt SHALL saturate; there SHALL be no further key_long until the next key_press.
REQ-022 key_long and key_release SHALL both assert in the same cycle when both conditions coincide.
REQ-023 key_press and key_release SHALL never assert in the same cycle, and there SHALL be exactly one key_release per key_press.
REQ-024 The block SHALL register all outputs directly, with no combinational path from key_in.

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL set the FSM to IDLE, both counters to 0, key_state, key_press, key_release and key_long to 0, and both synchronizer flops to the released level of key_in (1 when KEY_ACTIVE_LOW=1).
REQ-026 Reset asserted mid-operation, in any state, SHALL abort immediately, with no key_release pulse.
REQ-027 A key held through reset deassertion SHALL be debounced afresh and produce key_press per REQ-017.

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4, LONG_MS=20, so DB_CNT_MAX=3, LONG_CNT_MAX=19, KEY_ACTIVE_LOW=1)
REQ-028 The bench SHALL drive key_in=0 stable from edge 1 and require key_press high only after edge 7, and key_state=1 from edge 7.
REQ-029 The bench SHALL drive 2-cycle low glitches separated by 2-cycle highs for 40 cycles and require key_press, key_release and key_long to stay 0 and key_state=0.
REQ-030 The bench SHALL hold the key for 30 cycles after key_press and require exactly one key_long 20 cycles after key_press; a release then SHALL give one key_release 7 cycles after key_in returns to 1.
REQ-031 The bench SHALL, in HELD, drive key_in=1 for 2 cycles then 0, and require no key_release, key_state held at 1, and key_long timing unshifted.
REQ-032 The bench SHALL assert rst for 1 cycle while in HELD with key_in=0, and require all outputs 0 immediately after, then key_press again 7 edges after rst deasserts.
REQ-033 The bench SHALL release the key so that the release debounce completes exactly as long_cnt reaches 19, and require key_long and key_release high in the same cycle.

Source files
------------

// File: rtl/key_debounce.sv
// Debounced push-button with press/release/long-press pulse outputs.
// Raw key is synchronized, normalized to a "pressed" bit, then filtered by a four-state FSM.
module key_debounce #(
  parameter int unsigned CLK_FREQ       = 50000000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned LONG_MS        = 1000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam logic [31:0] DB_CNT_MAX   = 32'(CLK_FREQ / 1000 * DEBOUNCE_MS - 1);
  localparam logic [31:0] LONG_CNT_MAX = 32'(CLK_FREQ / 1000 * LONG_MS - 1);
  localparam logic        RELEASED_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  if (DB_CNT_MAX < 32'd1 || LONG_CNT_MAX <= DB_CNT_MAX) begin : g_bad_params
    $error("key_debounce: need DB_CNT_MAX >= 1 and LONG_CNT_MAX > DB_CNT_MAX");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic [31:0] long_cnt_q, long_cnt_d;
  logic        long_done_q, long_done_d;
  logic        key_state_q, key_state_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        sync1_q, sync2_q;
  logic        pressed;

  assign pressed = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= RELEASED_LVL;
      sync2_q     <= RELEASED_LVL;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= key_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    long_cnt_d  = long_cnt_q;
    long_done_d = long_done_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_CNT_MAX) begin
          state_d     = HELD;
          key_state_d = 1'b1;
          press_d     = 1'b1;
          db_cnt_d    = '0;
          long_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_CNT_MAX) begin
          state_d     = IDLE;
          key_state_d = 1'b0;
          release_d   = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Long-press timing keeps running through a release bounce, so a bounce never shifts it.
    if (state_q == HELD || state_q == RELEASE_DB) begin
      if (long_cnt_q < LONG_CNT_MAX) begin
        long_cnt_d = long_cnt_q + 32'd1;
      end else if (!long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulses, a monitor pops and compares them.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic key_state;
  logic key_press;
  logic key_release;
  logic key_long;

  key_debounce #(
    .CLK_FREQ      (1000),
    .DEBOUNCE_MS   (4),
    .LONG_MS       (20),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; inputs change and outputs are sampled on falling edges.
  int edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Pulse kind is {press, release, long}.
  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } pulse_t;

  pulse_t     expQ[$];
  pulse_t     expItem;
  logic [2:0] seen;
  int         checks = 0;
  int         failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at edge %0d", name, actual, expected, edgeCount);
    end
  endtask

  task automatic expectPulse(input int cyc, input logic [2:0] kind);
    pulse_t item;
    item.cyc  = cyc;
    item.kind = kind;
    expQ.push_back(item);
  endtask

  task automatic applyStimulus(input logic k, input int cycles);
    key_in = k;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitUntil(input int target);
    while (edgeCount < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    seen = {key_press, key_release, key_long};
    if (seen != 3'b000) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, seen}, 32'd0);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("pulse_cycle", edgeCount, expItem.cyc);
        checkOutput("pulse_kind", {29'd0, seen}, {29'd0, expItem.kind});
      end
    end
  end

  initial begin
    int n;
    int m;
    rst    = 1'b1;
    key_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", key_state, 0);
    checkOutput("reset_press", key_press, 0);
    checkOutput("reset_release", key_release, 0);
    checkOutput("reset_long", key_long, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 5);

    // Short glitches never survive the debounce window.
    repeat (10) begin
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 2);
      checkOutput("glitch_state", key_state, 0);
    end
    applyStimulus(1'b1, 6);
    checkOutput("glitch_tail_state", key_state, 0);

    // Clean press, long hold, clean release.
    n = edgeCount;
    expectPulse(n + 7, 3'b100);
    expectPulse(n + 27, 3'b001);
    key_in = 1'b0;
    waitUntil(n + 6);
    checkOutput("press_state_before", key_state, 0);
    waitUntil(n + 7);
    checkOutput("press_state_after", key_state, 1);
    waitUntil(n + 37);
    m = edgeCount;
    expectPulse(m + 7, 3'b010);
    key_in = 1'b1;
    waitUntil(m + 6);
    checkOutput("release_state_before", key_state, 1);
    waitUntil(m + 7);
    checkOutput("release_state_after", key_state, 0);
    waitUntil(m + 12);

    // Release bounce while held: no release, long timing unchanged.
    n = edgeCount;
    expectPulse(n + 7, 3'b100);
    expectPulse(n + 27, 3'b001);
    key_in = 1'b0;
    waitUntil(n + 12);
    key_in = 1'b1;
    waitUntil(n + 14);
    key_in = 1'b0;
    waitUntil(n + 18);
    checkOutput("bounce_state", key_state, 1);
    waitUntil(n + 30);
    m = edgeCount;
    expectPulse(m + 7, 3'b010);
    key_in = 1'b1;
    waitUntil(m + 12);
    checkOutput("bounce_end_state", key_state, 0);

    // Reset while held aborts silently, then the still-held key is debounced again.
    n = edgeCount;
    expectPulse(n + 7, 3'b100);
    key_in = 1'b0;
    waitUntil(n + 10);
    rst = 1'b1;
    waitUntil(n + 11);
    rst = 1'b0;
    checkOutput("midreset_state", key_state, 0);
    checkOutput("midreset_press", key_press, 0);
    checkOutput("midreset_release", key_release, 0);
    checkOutput("midreset_long", key_long, 0);
    expectPulse(n + 18, 3'b100);
    expectPulse(n + 38, 3'b001);
    waitUntil(n + 17);
    checkOutput("repress_state_before", key_state, 0);
    waitUntil(n + 18);
    checkOutput("repress_state_after", key_state, 1);
    waitUntil(n + 40);
    m = edgeCount;
    expectPulse(m + 7, 3'b010);
    key_in = 1'b1;
    waitUntil(m + 12);

    // Release debounce completes on the same edge the long threshold is reached.
    n = edgeCount;
    expectPulse(n + 7, 3'b100);
    expectPulse(n + 27, 3'b011);
    key_in = 1'b0;
    waitUntil(n + 20);
    key_in = 1'b1;
    waitUntil(n + 32);
    checkOutput("coincide_end_state", key_state, 0);

    checkOutput("pending_pulses", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
